// File: rtl/fg_bd_scheduler.sv
// Periodic burst-descriptor scheduler: per-flow interval timers raise requests,
// which are granted round-robin and offered one at a time on a valid/ready stream.
module fg_bd_scheduler #(
    parameter int unsigned FLOW_COUNT     = 4,
    parameter int unsigned DEST_WIDTH     = 8,
    parameter int unsigned LEN_WIDTH      = 32,
    parameter int unsigned INTERVAL_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FLOW_COUNT-1:0]                flow_enable,
    input  logic [FLOW_COUNT*DEST_WIDTH-1:0]     flow_dest,
    input  logic [FLOW_COUNT*LEN_WIDTH-1:0]      flow_burst_len,
    input  logic [FLOW_COUNT*INTERVAL_WIDTH-1:0] flow_interval,
    output logic                                 output_bd_valid,
    input  logic                                 output_bd_ready,
    output logic [DEST_WIDTH-1:0]                output_bd_dest,
    output logic [LEN_WIDTH-1:0]                 output_bd_burst_len,
    output logic [FLOW_COUNT-1:0]                pending,
    output logic [FLOW_COUNT-1:0]                overrun,
    output logic                                 busy
);

    localparam int unsigned IDX_W = (FLOW_COUNT > 1) ? $clog2(FLOW_COUNT) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_last_grant;
    logic [FLOW_COUNT-1:0]     r_pending;
    logic [FLOW_COUNT-1:0]     r_overrun;
    logic                      r_valid;
    logic [DEST_WIDTH-1:0]     r_dest;
    logic [LEN_WIDTH-1:0]      r_len;
    logic                      r_busy;
    logic [INTERVAL_WIDTH-1:0] r_timer [FLOW_COUNT];

    logic [INTERVAL_WIDTH-1:0] w_reload [FLOW_COUNT];
    logic [FLOW_COUNT-1:0]     w_expire;
    logic [FLOW_COUNT-1:0]     w_grant;
    logic [FLOW_COUNT-1:0]     w_pending_nxt;
    logic [FLOW_COUNT-1:0]     w_overrun_nxt;
    logic                      w_found;
    logic [IDX_W-1:0]          w_sel;
    int unsigned               w_idx;
    logic [DEST_WIDTH-1:0]     w_sel_dest;
    logic [LEN_WIDTH-1:0]      w_sel_len;
    logic                      w_issue_nxt;

    // Round-robin search starting just after the last granted flow.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int unsigned off = 1; off <= FLOW_COUNT; off++) begin
            w_idx = 32'(r_last_grant) + off;
            if (w_idx >= FLOW_COUNT) begin
                w_idx = w_idx - FLOW_COUNT;
            end
            if (!w_found && r_pending[IDX_W'(w_idx)]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(w_idx);
            end
        end
    end

    assign w_sel_dest  = flow_dest[w_sel*DEST_WIDTH +: DEST_WIDTH];
    assign w_sel_len   = flow_burst_len[w_sel*LEN_WIDTH +: LEN_WIDTH];
    assign w_issue_nxt = (r_state == ST_IDLE) ? (w_found && (|w_sel_len))
                                              : !output_bd_ready;

    // An expiry in the same cycle as a grant re-arms the request silently.
    always_comb begin
        w_grant       = '0;
        w_expire      = '0;
        w_pending_nxt = '0;
        w_overrun_nxt = '0;
        if ((r_state == ST_IDLE) && w_found) begin
            w_grant[w_sel] = 1'b1;
        end
        for (int unsigned i = 0; i < FLOW_COUNT; i++) begin
            w_reload[i] = (flow_interval[i*INTERVAL_WIDTH +: INTERVAL_WIDTH] == '0) ? '0 :
                          flow_interval[i*INTERVAL_WIDTH +: INTERVAL_WIDTH] - 1'b1;
            w_expire[i]      = flow_enable[i] && (r_timer[i] == '0);
            w_pending_nxt[i] = flow_enable[i] && (w_expire[i] || (r_pending[i] && !w_grant[i]));
            w_overrun_nxt[i] = w_expire[i] && r_pending[i] && !w_grant[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FLOW_COUNT; i++) begin
                r_timer[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < FLOW_COUNT; i++) begin
                if (!flow_enable[i]) begin
                    r_timer[i] <= '0;
                end else if (w_expire[i]) begin
                    r_timer[i] <= w_reload[i];
                end else begin
                    r_timer[i] <= r_timer[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= IDX_W'(FLOW_COUNT - 1);
            r_pending    <= '0;
            r_overrun    <= '0;
            r_valid      <= 1'b0;
            r_dest       <= '0;
            r_len        <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
            r_busy    <= w_issue_nxt || (|w_pending_nxt);
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_last_grant <= w_sel;
                        // Zero-length requests are consumed without a descriptor.
                        if (|w_sel_len) begin
                            r_dest  <= w_sel_dest;
                            r_len   <= w_sel_len;
                            r_valid <= 1'b1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (output_bd_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign output_bd_valid     = r_valid;
    assign output_bd_dest      = r_dest;
    assign output_bd_burst_len = r_len;
    assign pending             = r_pending;
    assign overrun             = r_overrun;
    assign busy                = r_busy;

endmodule

// File: tb/tb_fg_bd_scheduler.sv
// Scoreboard bench for fg_bd_scheduler: an absolute-time reference model predicts
// descriptors into a queue that a separate handshake monitor drains and compares.
module tb_fg_bd_scheduler;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int LW = 32;
    localparam int IW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      en;
    logic [N*DW-1:0]   dest;
    logic [N*LW-1:0]   blen;
    logic [N*IW-1:0]   ival;
    logic              ready;
    logic              output_bd_valid;
    logic [DW-1:0]     output_bd_dest;
    logic [LW-1:0]     output_bd_burst_len;
    logic [N-1:0]      pending;
    logic [N-1:0]      overrun;
    logic              busy;

    fg_bd_scheduler #(
        .FLOW_COUNT    (N),
        .DEST_WIDTH    (DW),
        .LEN_WIDTH     (LW),
        .INTERVAL_WIDTH(IW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flow_enable        (en),
        .flow_dest          (dest),
        .flow_burst_len     (blen),
        .flow_interval      (ival),
        .output_bd_valid    (output_bd_valid),
        .output_bd_ready    (ready),
        .output_bd_dest     (output_bd_dest),
        .output_bd_burst_len(output_bd_burst_len),
        .pending            (pending),
        .overrun            (overrun),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct packed {
        logic [DW-1:0] d;
        logic [LW-1:0] l;
    } desc_t;

    desc_t exp_q[$];
    desc_t mon_e;

    // Reference model: each enabled flow is due at an absolute cycle; it becomes
    // due on its first enabled cycle, then every max(interval,1) cycles after.
    bit [N-1:0]    m_pend, m_ov, m_was_en, np, nov;
    longint        m_due [N];
    longint        now;
    int            m_last, g;
    bit            m_offer, m_busy, ex;
    logic [DW-1:0] m_dest;
    logic [LW-1:0] m_len;

    always @(negedge clk) begin
        if (!rst) begin
            m_pend = '0; m_ov = '0; m_was_en = '0;
            m_last = N - 1; m_offer = 0; m_busy = 0;
            exp_q.delete();
        end
        chk("valid", output_bd_valid, m_offer);
        chk("pending", pending, m_pend);
        chk("overrun", overrun, m_ov);
        chk("busy", busy, m_busy);
        if (m_offer) begin
            chk("hold_dest", output_bd_dest, m_dest);
            chk("hold_len", output_bd_burst_len, m_len);
        end
        if (rst) begin
            g = -1;
            if (!m_offer)
                for (int k = 1; k <= N; k++)
                    if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
            for (int i = 0; i < N; i++) begin
                if (!en[i]) begin
                    np[i] = 0; nov[i] = 0; m_was_en[i] = 0;
                end else begin
                    if (!m_was_en[i]) m_due[i] = now;
                    m_was_en[i] = 1;
                    ex = (m_due[i] == now);
                    if (ex) m_due[i] = now + ((ival[i*IW +: IW] == 0) ? 1 : longint'(ival[i*IW +: IW]));
                    np[i]  = ex || (m_pend[i] && g != i);
                    nov[i] = ex && m_pend[i] && g != i;
                end
            end
            if (m_offer) begin
                if (ready) m_offer = 0;
            end else if (g >= 0) begin
                m_last = g;
                if (blen[g*LW +: LW] != 0) begin
                    m_offer = 1;
                    m_dest  = dest[g*DW +: DW];
                    m_len   = blen[g*LW +: LW];
                    exp_q.push_back({m_dest, m_len});
                end
            end
            m_pend = np;
            m_ov   = nov;
            m_busy = m_offer || (|np);
            now++;
        end
    end

    // Handshake monitor: every accepted descriptor must match the oldest prediction.
    always @(negedge clk) begin
        if (rst && output_bd_valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("bd_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bd_dest", output_bd_dest, mon_e.d);
                chk("bd_len", output_bd_burst_len, mon_e.l);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_flow(input int i, input logic [DW-1:0] d, input logic [LW-1:0] l,
                            input logic [IW-1:0] iv, input logic e);
        dest[i*DW +: DW] = d;
        blen[i*LW +: LW] = l;
        ival[i*IW +: IW] = iv;
        en[i]            = e;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!output_bd_valid && k < 60) begin
            cyc(1);
            k++;
        end
        chk(nm, output_bd_valid, 1'b1);
    endtask

    initial begin
        en = '0; dest = '0; blen = '0; ival = '0; ready = 1'b0; now = 0;
        cyc(2);
        rst = 1'b1;

        // single flow
        set_flow(0, 8'h12, 32'd1000, 16'd10, 1'b1);
        ready = 1'b1;
        cyc(45);
        en = '0; cyc(3);

        // round-robin, interval 1 on every flow
        for (int i = 0; i < N; i++) set_flow(i, DW'(i), LW'(100 + i), 16'd1, 1'b1);
        cyc(40);
        en = '0; cyc(3);

        // backpressure
        set_flow(1, 8'h21, 32'd77, 16'd5, 1'b1);
        ready = 1'b0;
        cyc(20);
        ready = 1'b1;
        cyc(15);
        en = '0; cyc(3);

        // zero-length flow alongside a normal one
        set_flow(2, 8'h22, 32'd0, 16'd4, 1'b1);
        set_flow(3, 8'h33, 32'd64, 16'd4, 1'b1);
        cyc(30);
        en = '0; cyc(3);

        // disable while offered
        set_flow(0, 8'h40, 32'd5, 16'd20, 1'b1);
        ready = 1'b0;
        wait_valid("p5_offer");
        en[0] = 1'b0;
        cyc(3);
        ready = 1'b1;
        cyc(2);
        chk("p5_busy_low", busy, 1'b0);
        cyc(25);

        // asynchronous reset mid-offer
        for (int i = 0; i < N; i++) set_flow(i, DW'(8'h60 + i), 32'd8, 16'd3, 1'b1);
        ready = 1'b0;
        wait_valid("p6_offer");
        #2;
        rst = 1'b0;
        #1;
        chk("rst_valid", output_bd_valid, 1'b0);
        chk("rst_pending", pending, '0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_valid("p6_regrant");
        chk("rst_first_dest", output_bd_dest, 8'h60);
        ready = 1'b1;
        cyc(20);

        // randomized configurations and backpressure
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < N; i++)
                set_flow(i, DW'($urandom),
                         ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 5000)),
                         IW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            repeat (25) begin
                ready = ($urandom_range(0, 3) != 0);
                cyc(1);
            end
        end

        en = '0;
        ready = 1'b1;
        cyc(10);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", output_bd_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/fg_bd_scheduler.md
Name: fg_bd_scheduler

Overview:
Periodic burst-descriptor scheduler for the flow generator. It holds FLOW_COUNT programmed flows, each with a destination, burst length and issue interval, and raises a per-flow request when that flow's interval timer expires. Pending requests are granted round-robin and issued as single descriptors on a valid/ready descriptor stream that feeds the packet generator's burst descriptor input.

Parameters:
FLOW_COUNT, 4, number of flows (1..16)
DEST_WIDTH, 8, destination field width
LEN_WIDTH, 32, burst length field width
INTERVAL_WIDTH, 16, interval timer width (cycles)

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is asynchronous and active-low
flow_enable  input  FLOW_COUNT  per-flow enable
flow_dest  input  FLOW_COUNT*DEST_WIDTH  per-flow destination, flow i at [i*DEST_WIDTH +: DEST_WIDTH]
flow_burst_len  input  FLOW_COUNT*LEN_WIDTH  per-flow burst length, same packing
flow_interval  input  FLOW_COUNT*INTERVAL_WIDTH  per-flow issue period in cycles, same packing
output_bd_valid  output  1  descriptor valid
output_bd_ready  input  1  descriptor accepted by downstream
output_bd_dest  output  DEST_WIDTH  descriptor destination
output_bd_burst_len  output  LEN_WIDTH  descriptor burst length
pending  output  FLOW_COUNT  per-flow request outstanding
overrun  output  FLOW_COUNT  one-cycle pulse: flow timer expired while its request was still pending
busy  output  1  any pending bit set or descriptor being offered

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; timers 0; FSM in IDLE; last_grant = FLOW_COUNT-1, so flow 0 has first priority.
- Timers, per flow i:
  - flow_enable[i]=0: timer[i]=0, pending[i]=0; overrun[i] is not asserted.
  - Enabled and timer[i]==0: set pending[i] (expiry event); reload timer[i] = max(interval,1)-1.
  - Enabled and timer[i]!=0: decrement timer[i].
  - The first expiry occurs in the first cycle after enable.
  - interval 0 behaves as interval 1: an expiry every cycle.
- Overrun: an expiry while pending[i]=1 that is not cleared by a grant in the same cycle pulses overrun[i] for 1 cycle. The request is merged; pending[i] stays set.
- Grant/expiry in the same cycle: the expiry wins, so pending[i] stays 1 and no overrun is signalled.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - If any pending bit is set, select the first pending flow searching from last_grant+1 upward, wrapping modulo FLOW_COUNT.
  - Clear that flow's pending bit and set last_grant to it.
  - If its burst_len != 0: register its dest and burst_len onto the outputs, assert output_bd_valid the next cycle, and go to ISSUE.
  - If its burst_len == 0: discard the request, emit no descriptor, and stay in IDLE.
- ISSUE:
  - Hold output_bd_valid, dest and burst_len stable until output_bd_valid && output_bd_ready.
  - On that handshake, drop valid the next cycle and return to IDLE.
  - Never retract a descriptor.
- Throughput: at most 1 descriptor every 2 cycles, since IDLE costs 1 cycle.
- Latency: a request pending in IDLE at cycle t gives output_bd_valid=1 at t+1.
- Config changes while in ISSUE do not alter the latched descriptor. Disabling the offered flow mid-ISSUE still completes that descriptor.
- Config changes take effect at the next timer reload or next grant.
- busy = (state==ISSUE) | (|pending), registered with the state.
- Reset mid-ISSUE: output_bd_valid drops asynchronously and any in-flight descriptor is lost.

Test Plan:
1. Single flow: enable flow 0 (dest=0x12, len=1000, interval=10), ready=1 → a descriptor {0x12,1000} handshakes every 10 cycles, first at 2 cycles after enable; overrun stays 0.
2. Round-robin: all 4 flows interval=1, distinct dest 0..3, ready=1 → descriptor dest sequence 0,1,2,3,0,1… with no flow repeated before all others are served; overrun pulses on every flow.
3. Backpressure: flow 1 interval=5, ready held 0 for 20 cycles → one descriptor is held stable throughout, pending[1] re-set, overrun[1] pulses each subsequent expiry; on ready=1 exactly 1 handshake, then the next one issues within 2 cycles.
4. Zero length: flow 2 len=0 interval=4 with flow 3 len=64 interval=4 → only dest of flow 3 appears, pending[2] clears each grant, and output_bd_valid never asserts for flow 2.
5. Disable while offered: flow 0 in ISSUE, deassert flow_enable[0] → descriptor still completes on ready, pending[0]=0 afterwards, no further flow 0 descriptors; busy falls to 0 the cycle after the handshake.
6. Async reset mid-ISSUE: drive rst=0 between clock edges with valid=1 → valid, pending and busy go 0 immediately; after release the first grant goes to flow 0.
